mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit in the EX stage. It serves the MULT, MULTU, DIV and
//   DIVU operations that the single-cycle ALU does not implement, and owns the HI/LO
//   registers. It takes operands from EX on a start pulse and asserts busy while it runs.
//   Hazard logic stalls MFHI, MFLO and any new mult/div while busy=1.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits; RUN lasts WIDTH cycles
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      issue the operation selected by op, using a and b
//   op       in   2      00=MULT, 01=MULTU, 10=DIV, 11=DIVU
//   a        in   WIDTH  rs operand (multiplicand / dividend)
//   b        in   WIDTH  rt operand (multiplier / divisor)
//   mthi     in   1      write wdata to HI (MTHI)
//   mtlo     in   1      write wdata to LO (MTLO)
//   wdata    in   WIDTH  data for mthi/mtlo
//   busy     out  1      operation in flight; start, mthi and mtlo are ignored while high
//   done     out  1      one-cycle pulse: hi/lo hold the new result from this cycle on
//   hi       out  WIDTH  HI register (product[2W-1:W] or remainder)
//   lo       out  WIDTH  LO register (product[W-1:0] or quotient)
// BEHAVIOUR
//   Reset (asynchronous, any state): state=IDLE, busy=0, done=0, hi=0, lo=0; any
//     in-flight operation is discarded.
//   FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE:
//     - start=1: latch op and the magnitudes of a and b. Signed ops (op[0]=0) take
//       the absolute value and record the sign bits sa, sb; unsigned ops pass
//       through unchanged. Clear the 2W accumulator and set the counter to WIDTH-1.
//       Go to RUN; busy=1 from the next cycle.
//     - start has priority: if start and mthi/mtlo are high in the same cycle,
//       start is accepted and the mthi/mtlo write is dropped.
//     - With start=0: mthi writes HI and mtlo writes LO at this edge. Both may be
//       high together. done stays 0.
//   RUN (exactly WIDTH cycles, one result bit per cycle):
//     - Multiply: shift-add radix-2; WIDTH-bit adder with carry into the 2W accumulator.
//     - Divide: restoring shift-subtract; each cycle shifts one remainder bit in and
//       one quotient bit out.
//     - When the counter reaches 0, go to FIX.
//   FIX (1 cycle): apply sign correction, load hi/lo, pulse done=1, drop busy,
//     return to IDLE.
//     - Signed MULT: negate the 2W product if sa^sb.
//     - Signed DIV: negate the quotient if sa^sb; negate the remainder if sa.
//     - Divide by zero (b=0, any DIV op): LO = all ones, HI = a (the original
//       signed value, not its magnitude).
//     - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps; no trap).
//   Latency: start sampled at edge N; busy=1 for cycles N+1..N+WIDTH+1; done=1 and
//     new hi/lo in cycle N+WIDTH+1; busy=0 and a new start can be accepted at edge
//     N+WIDTH+2.
//   hi/lo keep their old values during RUN and change only in FIX.
//   start while busy=1: ignored, with no effect on the running operation.
//   Output timing: busy and done are registered outputs (no combinational path
//     from any input). hi and lo are driven directly from flops.
// TESTING
//   1 MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles done=1,
//     hi=0xFFFFFFFE, lo=0x00000001.
//   2 MULT: a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
//   3 DIV: a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU: a=100, b=7 -> lo=14, hi=2.
//   4 DIV and DIVU with b=0, a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678, and
//     done still pulses at cycle 34.
//   5 Handshake: start, then start again 5 cycles later with different operands,
//     then mthi=1 while busy -> only the first result appears, hi is not
//     overwritten, done pulses exactly once. In IDLE, mthi=mtlo=1 with
//     wdata=0xA5A5A5A5 -> both registers read 0xA5A5A5A5 next cycle.
//   6 Assert reset mid-RUN (cycle 10) -> busy=0, hi=lo=0 immediately; after
//     release, a fresh MULTU 3x5 gives lo=15 on the normal timeline.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO. It does a radix-2 shift-add
// multiply or a restoring divide, one result bit per cycle, then a sign fix-up.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [1:0]         op_r;
   logic               sa, sb, b_zero;
   logic [WIDTH-1:0]   a_orig;
   logic [WIDTH-1:0]   opa, opb;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     sum, trial, diff;
   logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, hi_fix, lo_fix;
   logic               neg_q;

   assign abs_a = (~op[0] & a[WIDTH-1]) ? -a : a;
   assign abs_b = (~op[0] & b[WIDTH-1]) ? -b : b;

   // multiply: acc holds {partial high, product bits shifted in from the top}
   assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
   // divide: acc holds {remainder, quotient}, dividend bits come from opa MSB
   assign trial = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
   assign diff  = trial - {1'b0, opb};

   assign neg_q = ~op_r[0] & (sa ^ sb);
   assign quo   = acc_nxt[WIDTH-1:0];
   assign rem   = acc_nxt[2*WIDTH-1:WIDTH];
   assign prod  = neg_q ? -acc_nxt : acc_nxt;

   always_comb begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
      if (op_r[1]) begin
         acc_nxt = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
      if (op_r[1]) begin
         if (b_zero) begin
            hi_fix = a_orig;
            lo_fix = '1;
         end else begin
            lo_fix = neg_q ? -quo : quo;
            hi_fix = (~op_r[0] & sa) ? -rem : rem;
         end
      end
   end

   // The last RUN step and the sign fix-up share one edge, so the FIX cycle
   // already shows the result with done=1 while busy is still high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         op_r   <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         b_zero <= 1'b0;
         a_orig <= '0;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r   <= op;
                  sa     <= ~op[0] & a[WIDTH-1];
                  sb     <= ~op[0] & b[WIDTH-1];
                  b_zero <= (b == '0);
                  a_orig <= a;
                  opa    <= abs_a;
                  opb    <= abs_b;
                  acc    <= '0;
                  cnt    <= CNT_INIT;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
               if (op_r[1]) opa <= opa << 1;
               else         opb <= opb >> 1;
               if (cnt == '0) begin
                  hi    <= hi_fix;
                  lo    <= lo_fix;
                  done  <= 1'b1;
                  state <= FIX;
               end
            end
            FIX: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
